// File: rtl/clock_pkg.sv
// Shared clock/calendar constants: mode encodings and field widths.
package clock_pkg;

  localparam logic [2:0] MODE_SET_DAY  = 3'b100;
  localparam logic [2:0] MODE_SET_MON  = 3'b101;
  localparam logic [2:0] MODE_SET_YEAR = 3'b110;
  localparam logic [2:0] MODE_SET_HOUR = 3'b111;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;
  localparam int unsigned DAY_W  = 5;
  localparam int unsigned MON_W  = 4;
  localparam int unsigned MODE_W = 3;

  // True for the modes in which the buttons edit a date field.
  function automatic logic is_date_edit_mode(input logic [MODE_W-1:0] m);
    return (m == MODE_SET_DAY) || (m == MODE_SET_MON) || (m == MODE_SET_YEAR);
  endfunction

endpackage

// File: rtl/date_counter_if.sv
// Time inputs, user controls and calendar outputs of the date stage.
interface date_counter_if
  import clock_pkg::*;
#(
  parameter int unsigned YEAR_W = 12
);

  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic              btn_up;
  logic              btn_down;
  logic [MODE_W-1:0] mode;
  logic [DAY_W-1:0]  day;
  logic [MON_W-1:0]  month;
  logic [YEAR_W-1:0] year;
  logic              leap;
  logic              day_tick;

  modport master (
    output sec, min, hour, btn_up, btn_down, mode,
    input  day, month, year, leap, day_tick
  );

  modport slave (
    input  sec, min, hour, btn_up, btn_down, mode,
    output day, month, year, leap, day_tick
  );

endinterface

// File: rtl/month_len.sv
// Days in a month for a given year, with the Gregorian leap-year flag.
module month_len
  import clock_pkg::*;
#(
  parameter int unsigned YEAR_W = 12
) (
  input  logic [MON_W-1:0]  month,
  input  logic [YEAR_W-1:0] year,
  output logic [DAY_W-1:0]  dim,
  output logic              leap
);

  always_comb begin
    leap = (((year % YEAR_W'(4)) == '0) && ((year % YEAR_W'(100)) != '0))
           || ((year % YEAR_W'(400)) == '0);
    dim  = DAY_W'(31);
    case (month)
      MON_W'(2):                         dim = leap ? DAY_W'(29) : DAY_W'(28);
      MON_W'(4), MON_W'(6),
      MON_W'(9), MON_W'(11):             dim = DAY_W'(30);
      default:                           dim = DAY_W'(31);
    endcase
  end

endmodule

// File: rtl/date_counter.sv
// Calendar stage: advances day/month/year at midnight rollover and applies
// button edits in the set modes, clamping the day into the month's range.
module date_counter
  import clock_pkg::*;
#(
  parameter int unsigned YEAR_MIN = 2000,
  parameter int unsigned YEAR_MAX = 2099,
  parameter int unsigned YEAR_W   = 12
) (
  input  logic          clk_1Hz,
  input  logic          rst,
  date_counter_if.slave bus
);

  logic [DAY_W-1:0]  day_q,   day_n;
  logic [MON_W-1:0]  month_q, month_n;
  logic [YEAR_W-1:0] year_q,  year_n;
  logic              tick_q,  tick_n;

  logic [DAY_W-1:0]  cur_dim, cand_dim;
  logic              cur_leap, cand_leap_unused;
  logic [MON_W-1:0]  cand_month;
  logic [YEAR_W-1:0] cand_year;

  logic rollover, edit, up;

  month_len #(.YEAR_W(YEAR_W)) u_cur_len (
    .month (month_q),
    .year  (year_q),
    .dim   (cur_dim),
    .leap  (cur_leap)
  );

  month_len #(.YEAR_W(YEAR_W)) u_cand_len (
    .month (cand_month),
    .year  (cand_year),
    .dim   (cand_dim),
    .leap  (cand_leap_unused)
  );

  // Midnight detect is suppressed while the hour itself is being set.
  assign rollover = (bus.sec == SEC_W'(59)) && (bus.min == MIN_W'(59))
                    && (bus.hour == HOUR_W'(23)) && (bus.mode != MODE_SET_HOUR);
  assign edit     = is_date_edit_mode(bus.mode) && (~bus.btn_up | ~bus.btn_down);
  assign up       = ~bus.btn_up;

  // Month/year after a month or year edit; feeds the clamp lookup.
  always_comb begin
    cand_month = month_q;
    cand_year  = year_q;
    if (edit && (bus.mode == MODE_SET_MON)) begin
      if (up) cand_month = (month_q >= MON_W'(12)) ? MON_W'(1) : month_q + MON_W'(1);
      else    cand_month = (month_q <= MON_W'(1)) ? MON_W'(12) : month_q - MON_W'(1);
    end
    if (edit && (bus.mode == MODE_SET_YEAR)) begin
      if (up) cand_year = (year_q >= YEAR_W'(YEAR_MAX)) ? YEAR_W'(YEAR_MIN) : year_q + YEAR_W'(1);
      else    cand_year = (year_q <= YEAR_W'(YEAR_MIN)) ? YEAR_W'(YEAR_MAX) : year_q - YEAR_W'(1);
    end
  end

  // Next-state mux: edits take precedence over the automatic advance.
  always_comb begin
    day_n   = day_q;
    month_n = month_q;
    year_n  = year_q;
    tick_n  = 1'b0;
    if (edit) begin
      case (bus.mode)
        MODE_SET_DAY: begin
          if (up) day_n = (day_q >= cur_dim) ? DAY_W'(1) : day_q + DAY_W'(1);
          else    day_n = (day_q <= DAY_W'(1)) ? cur_dim : day_q - DAY_W'(1);
        end
        default: begin
          month_n = cand_month;
          year_n  = cand_year;
          day_n   = (day_q > cand_dim) ? cand_dim : day_q;
        end
      endcase
    end else if (rollover) begin
      tick_n = 1'b1;
      if (day_q < cur_dim) begin
        day_n = day_q + DAY_W'(1);
      end else begin
        day_n = DAY_W'(1);
        if (month_q >= MON_W'(12)) begin
          month_n = MON_W'(1);
          year_n  = (year_q >= YEAR_W'(YEAR_MAX)) ? YEAR_W'(YEAR_MIN) : year_q + YEAR_W'(1);
        end else begin
          month_n = month_q + MON_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      day_q   <= DAY_W'(1);
      month_q <= MON_W'(1);
      year_q  <= YEAR_W'(YEAR_MIN);
      tick_q  <= 1'b0;
    end else begin
      day_q   <= day_n;
      month_q <= month_n;
      year_q  <= year_n;
      tick_q  <= tick_n;
    end
  end

  assign bus.day      = day_q;
  assign bus.month    = month_q;
  assign bus.year     = year_q;
  assign bus.leap     = cur_leap;
  assign bus.day_tick = tick_q;

endmodule
